proc_control_unit: RTL and testbench

PROC_CONTROL_UNIT -- requirements
Module: proc_control_unit

---
 rtl/proc_control_unit.sv | 136 +++++++++++++
 tb/tb_proc_control_unit.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/proc_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : proc_control_unit
// Brief    : Four-step (T0-T3) control sequencer for a simple 9-bit-instruction
//            processor: mv, mvi, add, sub, mul, shift; flags undefined opcodes.
// Revision : 1.0 - initial release
// ============================================================================
module proc_control_unit (
    input  logic        clk,
    input  logic        rst,
    input  logic        run,
    input  logic [8:0]  din,
    output logic [8:0]  ir,
    output logic [3:0]  bus_sel,
    output logic [7:0]  r_in,
    output logic        a_in,
    output logic        g_in,
    output logic [2:0]  alu_op,
    output logic        done,
    output logic        busy,
    output logic        illegal,
    output logic [15:0] icount
);

    typedef enum logic [1:0] {
        T0 = 2'd0,
        T1 = 2'd1,
        T2 = 2'd2,
        T3 = 2'd3
    } state_t;

    localparam logic [2:0] c_OP_MV    = 3'b000;
    localparam logic [2:0] c_OP_MVI   = 3'b001;
    localparam logic [2:0] c_OP_ADD   = 3'b010;
    localparam logic [2:0] c_OP_SUB   = 3'b011;
    localparam logic [2:0] c_OP_MUL   = 3'b100;
    localparam logic [2:0] c_OP_SHIFT = 3'b101;

    localparam logic [3:0] c_SEL_G    = 4'b1000;
    localparam logic [3:0] c_SEL_IMM  = 4'b1001;
    localparam logic [3:0] c_SEL_IDLE = 4'b1111;

    state_t      r_state;
    state_t      w_next;
    logic [8:0]  r_ir;
    logic [15:0] r_icount;

    logic [2:0]  w_op;
    logic [2:0]  w_rx;
    logic [2:0]  w_ry;
    logic [7:0]  w_rx_onehot;

    assign w_op        = r_ir[8:6];
    assign w_rx        = r_ir[5:3];
    assign w_ry        = r_ir[2:0];
    assign w_rx_onehot = 8'b0000_0001 << w_rx;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= T0;
            r_ir     <= 9'd0;
            r_icount <= 16'd0;
        end else begin
            r_state <= w_next;
            if (r_state == T0 && run)
                r_ir <= din;
            if (done && !illegal)
                r_icount <= r_icount + 16'd1;
        end
    end

    // Reset masks every output so an interrupted instruction never signals done.
    always_comb begin
        w_next  = T0;
        bus_sel = c_SEL_IDLE;
        r_in    = 8'd0;
        a_in    = 1'b0;
        g_in    = 1'b0;
        alu_op  = 3'b000;
        done    = 1'b0;
        illegal = 1'b0;
        if (!rst) begin
            case (r_state)
                T0: begin
                    w_next = run ? T1 : T0;
                end
                T1: begin
                    case (w_op)
                        c_OP_MV: begin
                            bus_sel = {1'b0, w_ry};
                            r_in    = w_rx_onehot;
                            done    = 1'b1;
                        end
                        c_OP_MVI: begin
                            bus_sel = c_SEL_IMM;
                            r_in    = w_rx_onehot;
                            done    = 1'b1;
                        end
                        c_OP_ADD, c_OP_SUB, c_OP_MUL, c_OP_SHIFT: begin
                            bus_sel = {1'b0, w_rx};
                            a_in    = 1'b1;
                            w_next  = T2;
                        end
                        default: begin
                            illegal = 1'b1;
                            done    = 1'b1;
                        end
                    endcase
                end
                T2: begin
                    bus_sel = {1'b0, w_ry};
                    g_in    = 1'b1;
                    w_next  = T3;
                    case (w_op)
                        c_OP_ADD:   alu_op = 3'b001;
                        c_OP_SUB:   alu_op = 3'b010;
                        c_OP_SHIFT: alu_op = 3'b011;
                        default:    alu_op = 3'b000;
                    endcase
                end
                T3: begin
                    bus_sel = c_SEL_G;
                    r_in    = w_rx_onehot;
                    done    = 1'b1;
                end
                default: w_next = T0;
            endcase
        end
    end

    assign busy   = (r_state != T0) && !rst;
    assign ir     = r_ir;
    assign icount = r_icount;

endmodule
`default_nettype wire

// File: tb/tb_proc_control_unit.sv
`default_nettype none
// ============================================================================
// Module   : tb_proc_control_unit
// Brief    : Directed self-checking bench for proc_control_unit.
// Revision : 1.0 - initial release
// ============================================================================
module tb_proc_control_unit;

    logic        clk;
    logic        rst;
    logic        run;
    logic [8:0]  din;
    logic [8:0]  ir;
    logic [3:0]  bus_sel;
    logic [7:0]  r_in;
    logic        a_in;
    logic        g_in;
    logic [2:0]  alu_op;
    logic        done;
    logic        busy;
    logic        illegal;
    logic [15:0] icount;

    int n_checks;
    int n_fails;

    proc_control_unit dut (
        .clk     (clk),
        .rst     (rst),
        .run     (run),
        .din     (din),
        .ir      (ir),
        .bus_sel (bus_sel),
        .r_in    (r_in),
        .a_in    (a_in),
        .g_in    (g_in),
        .alu_op  (alu_op),
        .done    (done),
        .busy    (busy),
        .illegal (illegal),
        .icount  (icount)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Checks the full control vector of the current step.
    task automatic chk_ctl(input string tag, input logic [3:0] e_bus, input logic [7:0] e_rin,
                           input logic e_a, input logic e_g, input logic [2:0] e_alu,
                           input logic e_done, input logic e_ill, input logic e_busy);
        chk({tag, ".bus_sel"}, {12'd0, bus_sel}, {12'd0, e_bus});
        chk({tag, ".r_in"},    {8'd0, r_in},     {8'd0, e_rin});
        chk({tag, ".a_in"},    {15'd0, a_in},    {15'd0, e_a});
        chk({tag, ".g_in"},    {15'd0, g_in},    {15'd0, e_g});
        chk({tag, ".alu_op"},  {13'd0, alu_op},  {13'd0, e_alu});
        chk({tag, ".done"},    {15'd0, done},    {15'd0, e_done});
        chk({tag, ".illegal"}, {15'd0, illegal}, {15'd0, e_ill});
        chk({tag, ".busy"},    {15'd0, busy},    {15'd0, e_busy});
    endtask

    task automatic issue_mv(input logic [8:0] word);
        din = word;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        n_checks = 0;
        n_fails  = 0;
        rst = 1'b1;
        run = 1'b0;
        din = 9'd0;

        // Reset state
        @(negedge clk);
        @(negedge clk);
        chk_ctl("rst_hold", 4'hF, 8'h00, 0, 0, 3'd0, 0, 0, 0);
        chk("rst_hold.ir", {7'd0, ir}, 16'h0000);
        chk("rst_hold.icount", icount, 16'h0000);
        rst = 1'b0;
        @(negedge clk);
        chk_ctl("idle", 4'hF, 8'h00, 0, 0, 3'd0, 0, 0, 0);

        // mv R3 <- R5
        din = 9'b000_011_101;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        chk_ctl("mv.T1", 4'b0101, 8'b0000_1000, 0, 0, 3'd0, 1, 0, 1);
        chk("mv.ir", {7'd0, ir}, 16'h001D);
        @(negedge clk);
        chk_ctl("mv.T0", 4'hF, 8'h00, 0, 0, 3'd0, 0, 0, 0);
        chk("mv.icount", icount, 16'd1);

        // add R1 <- R1 + R2
        din = 9'b010_001_010;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        chk_ctl("add.T1", 4'b0001, 8'h00, 1, 0, 3'd0, 0, 0, 1);
        @(negedge clk);
        chk_ctl("add.T2", 4'b0010, 8'h00, 0, 1, 3'b001, 0, 0, 1);
        @(negedge clk);
        chk_ctl("add.T3", 4'b1000, 8'b0000_0010, 0, 0, 3'd0, 1, 0, 1);
        @(negedge clk);
        chk("add.icount", icount, 16'd2);
        chk("add.busy", {15'd0, busy}, 16'd0);

        // mvi R7 <- 0x1FF
        din = 9'b001_111_000;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        din = 9'h1FF;
        chk_ctl("mvi.T1", 4'b1001, 8'b1000_0000, 0, 0, 3'd0, 1, 0, 1);
        chk("mvi.ir", {7'd0, ir}, 16'h0078);
        @(negedge clk);
        chk("mvi.icount", icount, 16'd3);

        // mul R2 <- R2 * R3 with run held high throughout
        din = 9'b100_010_011;
        run = 1'b1;
        @(negedge clk);
        din = 9'h1FF;
        chk_ctl("mul.T1", 4'b0010, 8'h00, 1, 0, 3'd0, 0, 0, 1);
        chk("mul.T1.ir", {7'd0, ir}, 16'h0113);
        @(negedge clk);
        chk_ctl("mul.T2", 4'b0011, 8'h00, 0, 1, 3'b000, 0, 0, 1);
        chk("mul.T2.ir", {7'd0, ir}, 16'h0113);
        @(negedge clk);
        chk_ctl("mul.T3", 4'b1000, 8'b0000_0100, 0, 0, 3'd0, 1, 0, 1);
        chk("mul.T3.ir", {7'd0, ir}, 16'h0113);
        run = 1'b0;
        @(negedge clk);
        chk("mul.icount", icount, 16'd4);
        chk("mul.hold_ir", {7'd0, ir}, 16'h0113);

        // Undefined opcodes 111 and 110
        din = 9'b111_000_000;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        chk_ctl("ill7.T1", 4'hF, 8'h00, 0, 0, 3'd0, 1, 1, 1);
        @(negedge clk);
        chk("ill7.icount", icount, 16'd4);
        chk("ill7.busy", {15'd0, busy}, 16'd0);
        din = 9'b110_101_011;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        chk_ctl("ill6.T1", 4'hF, 8'h00, 0, 0, 3'd0, 1, 1, 1);
        @(negedge clk);
        chk("ill6.icount", icount, 16'd4);

        // sub R5 <- R5 - R6, reset during T2
        din = 9'b011_101_110;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        chk_ctl("sub.T1", 4'b0101, 8'h00, 1, 0, 3'd0, 0, 0, 1);
        @(negedge clk);
        chk_ctl("sub.T2", 4'b0110, 8'h00, 0, 1, 3'b010, 0, 0, 1);
        rst = 1'b1;
        run = 1'b1;
        #1;
        chk_ctl("sub.rst_T2", 4'hF, 8'h00, 0, 0, 3'd0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        run = 1'b0;
        #1;
        chk_ctl("sub.after_rst", 4'hF, 8'h00, 0, 0, 3'd0, 0, 0, 0);
        chk("sub.after_rst.ir", {7'd0, ir}, 16'h0000);
        chk("sub.after_rst.icount", icount, 16'h0000);
        @(negedge clk);
        chk_ctl("sub.idle", 4'hF, 8'h00, 0, 0, 3'd0, 0, 0, 0);
        chk("sub.idle.icount", icount, 16'h0000);

        // shift R6 <- R6 shifted by R6 (Rx = Ry)
        din = 9'b101_110_110;
        run = 1'b1;
        @(negedge clk);
        run = 1'b0;
        chk_ctl("shf.T1", 4'b0110, 8'h00, 1, 0, 3'd0, 0, 0, 1);
        @(negedge clk);
        chk_ctl("shf.T2", 4'b0110, 8'h00, 0, 1, 3'b011, 0, 0, 1);
        @(negedge clk);
        chk_ctl("shf.T3", 4'b1000, 8'b0100_0000, 0, 0, 3'd0, 1, 0, 1);
        @(negedge clk);
        chk("shf.icount", icount, 16'd1);

        // Counter wrap: preload near the top, then retire two instructions
        force dut.r_icount = 16'hFFFE;
        @(negedge clk);
        release dut.r_icount;
        @(negedge clk);
        chk("wrap.preload", icount, 16'hFFFE);
        issue_mv(9'b000_000_001);
        chk("wrap.ffff", icount, 16'hFFFF);
        issue_mv(9'b000_111_111);
        chk("wrap.zero", icount, 16'h0000);
        issue_mv(9'b000_100_010);
        chk("wrap.one", icount, 16'h0001);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
